// File: rtl/fir_output_serializer.sv
// Serializes signed FIR results into a byte stream for a UART transmitter.
// Each word is sign-extended to byte_count bytes and sent MSB byte first.
// A 2-entry word FIFO absorbs results that arrive while a word is in flight.
module fir_output_serializer #(
    parameter int unsigned output_width = 38,
    parameter int unsigned byte_count   = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    Output_Valid,
    input  logic [output_width-1:0] FIR_Output,
    input  logic                    Tx_Ready,
    output logic                    Tx_Valid,
    output logic [7:0]              Tx_Data,
    output logic                    Busy,
    output logic                    Overflow
);

    localparam int unsigned BW     = byte_count * 8;
    localparam int unsigned KW     = (byte_count > 1) ? $clog2(byte_count) : 1;
    localparam int unsigned LAST_K = byte_count - 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [output_width-1:0] head_q, head_d;
    logic [output_width-1:0] tail_q, tail_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;

    logic                    xfer;
    logic                    last_xfer;
    logic                    push;
    logic [BW-1:0]           ext;

    // Next-state: FIFO push/pop, byte index, FSM and registered outputs
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        ext        = '0;

        xfer      = tx_valid_q & Tx_Ready;
        last_xfer = xfer & (k_q == KW'(LAST_K));
        // A full FIFO still takes a word when the head leaves in the same cycle
        push      = Output_Valid & ((cnt_q != 2'd2) | last_xfer);

        if (Output_Valid && !push) begin
            ovf_d = 1'b1;
        end

        // FIFO update: head is entry 0, tail is entry 1
        case ({last_xfer, push})
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = FIR_Output;
                end else begin
                    head_d = FIR_Output;
                end
            end
            2'b10: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd0) begin
                    head_d = FIR_Output;
                end else begin
                    tail_d = FIR_Output;
                end
                cnt_d = cnt_q + 2'd1;
            end
            default: ;
        endcase

        // Byte-sequencing FSM
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = SEND;
                    k_d     = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (last_xfer) begin
                        k_d = '0;
                        if (cnt_d == 2'd0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase

        // Outputs are precomputed from next state so they register cleanly
        ext        = BW'($signed(head_d));
        tx_valid_d = (state_d == SEND);
        busy_d     = (cnt_d != 2'd0);
        if (state_d == SEND) begin
            tx_data_d = 8'(ext >> (8 * (LAST_K - 32'(k_d))));
        end else begin
            tx_data_d = 8'h00;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            cnt_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Tx_Valid = tx_valid_q;
    assign Tx_Data  = tx_data_q;
    assign Busy     = busy_q;
    assign Overflow = ovf_q;

endmodule

// File: doc/fir_output_serializer.md
FIR_OUTPUT_SERIALIZER -- requirements
Module: fir_output_serializer

Interface
REQ-001 The module SHALL have a parameter output_width, default 38, giving the width of the filter result word accepted.
REQ-002 The module SHALL have a parameter byte_count, default 5 (ceil(output_width/8)), giving the number of bytes sent per word.
REQ-003 The module SHALL have a single clock domain with an asynchronous, active-low reset.
REQ-004 The ports SHALL be as follows:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- Output_Valid  input  1  one-cycle strobe; FIR_Output holds a new result this cycle.
- FIR_Output  input  output_width  signed filter result, sampled when Output_Valid=1.
- Tx_Ready  input  1  UART transmitter can accept a byte this cycle.
- Tx_Valid  output  1  Tx_Data holds a byte to send.
- Tx_Data  output  8  byte to the UART transmitter.
- Busy  output  1  at least one word is buffered or in transmission.
- Overflow  output  1  sticky flag: a word was dropped.

Function
REQ-005 Each accepted word SHALL be sign-extended to byte_count*8 bits (40 by default) and sent MSB byte first, as byte_count bytes.
REQ-006 A byte SHALL be transferred in any cycle where Tx_Valid=1 and Tx_Ready=1; no other cycle transfers a byte.
REQ-007 While Tx_Valid=1 and Tx_Ready=0, Tx_Data and Tx_Valid SHALL hold their values unchanged.
REQ-008 A 2-entry word FIFO SHALL buffer the accepted words; the head entry is the word being sent.
REQ-009 The FSM SHALL have two states:
- IDLE: FIFO empty, Tx_Valid=0.
- SEND: head word present, Tx_Valid=1, byte index k from 0 to byte_count-1.
REQ-010 In IDLE, Output_Valid=1 SHALL write the word and enter SEND with k=0 on the next edge, giving Tx_Valid=1 one cycle after the strobe.
REQ-011 In SEND, a transfer with k<byte_count-1 SHALL increment k.
REQ-012 In SEND, a transfer with k=byte_count-1 SHALL pop the head.
- If the FIFO is then non-empty, the FSM SHALL reset k to 0 and stay in SEND with no idle cycle between words.
- Otherwise the FSM SHALL return to IDLE.
REQ-013 Output_Valid=1 with fewer than 2 entries SHALL accept the word.
REQ-014 Output_Valid=1 with 2 entries SHALL accept the word only if the last byte of the head transfers in the same cycle (pop and push together).
- Otherwise the word SHALL be dropped, FIFO contents SHALL be unchanged, and Overflow SHALL be set to 1.
REQ-015 Overflow SHALL remain 1 until reset.
REQ-016 Busy SHALL equal 1 whenever the FIFO is non-empty, and 0 otherwise.
REQ-017 Word order SHALL be preserved; no accepted word may be lost, duplicated or reordered.
REQ-018 FIR_Output SHALL be ignored when Output_Valid=0.

Reset
REQ-019 While reset=0, the module SHALL be in IDLE with FIFO empty, k=0, Tx_Valid=0, Tx_Data=8'h00, Busy=0 and Overflow=0.
REQ-020 Reset asserted mid-word SHALL abandon all partial and buffered words; no remaining bytes are sent after release.
REQ-021 After reset release, the first Output_Valid SHALL be handled as in REQ-010.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Tx_Ready tied 1, one strobe with FIR_Output=38'h0123456789 -> Tx_Valid for 5 consecutive cycles starting the next cycle, bytes 01,23,45,67,89, then Busy=0.
- Negative value FIR_Output=38'h3FFFFFFFFE (-2) -> bytes FF,FF,FF,FF,FE (sign-extended).
- Tx_Ready toggled 1,0,0,1,... during a word -> Tx_Data held while Ready=0, exactly 5 transfers, correct order.
- Three strobes 1 cycle apart, Tx_Ready=0 -> first two words buffered, third dropped, Overflow=1; after Ready=1, exactly 10 bytes sent, back-to-back across the word boundary.
- FIFO full, strobe coincident with the last-byte transfer of the head -> word accepted, Overflow stays 0, 15 bytes total sent.
- reset=0 asserted after byte 2 of a word -> Tx_Valid=0 immediately; after release no residual bytes; a new strobe sends a fresh 5-byte word.
